if_fetch_queue: RTL and testbench

Instruction-fetch front end of the pipelined RISC-V core. Owns the program counter, drives the combinational, word-aligned instruction memory each cycle, and buffers fetched {pc, instruction} pairs in a small FIFO. The decode stage consumes them over a valid/ready handshake. A redirect from execute (taken branch/jump) flushes the queue and restarts fetch at the target.

---
 rtl/if_fetch_queue.sv | 173 +++++++++++++++++
 tb/tb_if_fetch_queue.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: PC register, combinational imem fetch, and an
// in-order {pc, inst} queue toward decode. Optional misaligned-redirect trap
// is enabled by defining IF_FETCH_MISALIGN_TRAP_EN.
module if_fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   output logic [31:0] out_pc_plus4,
   output logic        out_fault
);

   localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   // Handshake: an entry moves to decode on every cycle where out_valid and
   // out_ready are both high; out_valid never depends on out_ready.

   logic [31:0]      pc_q, pc_d;
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      ent_pc_q   [DEPTH];
   logic [31:0]      ent_pc_d   [DEPTH];
   logic [31:0]      ent_inst_q [DEPTH];
   logic [31:0]      ent_inst_d [DEPTH];

   logic        pop;
   logic        push;
   logic        has_space;
   logic        halt;
   logic        trap_pend;
   logic [31:0] push_inst;
   logic [31:0] redirect_target;

`ifdef IF_FETCH_MISALIGN_TRAP_EN
   // RUN: normal fetch. TRAP: next push is the faulting NOP. HALT: no pushes.
   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_TRAP = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_t;

   fetch_state_t state_q, state_d;
   logic         ent_fault_q [DEPTH];
   logic         ent_fault_d [DEPTH];

   assign halt            = (state_q == ST_HALT);
   assign trap_pend       = (state_q == ST_TRAP);
   assign redirect_target = redirect_pc;
`else
   assign halt            = 1'b0;
   assign trap_pend       = 1'b0;
   assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
`endif

   assign imem_addr    = pc_q;
   assign out_valid    = (count_q != '0);
   assign out_pc       = ent_pc_q[head_q];
   assign out_inst     = ent_inst_q[head_q];
   assign out_pc_plus4 = ent_pc_q[head_q] + 32'd4;

`ifdef IF_FETCH_MISALIGN_TRAP_EN
   assign out_fault = ent_fault_q[head_q];
`else
   assign out_fault = 1'b0;
`endif

   always_comb begin
      pop       = out_valid & out_ready;
      has_space = (count_q < CNT_W'(DEPTH)) | pop;
      push      = ~redirect_valid & ~halt & has_space;
      push_inst = trap_pend ? NOP_INST : imem_rdata;

      pc_d    = pc_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      for (int i = 0; i < int'(DEPTH); i++) begin
         ent_pc_d[i]   = ent_pc_q[i];
         ent_inst_d[i] = ent_inst_q[i];
      end

      if (redirect_valid) begin
         // A pop in this cycle still reaches decode; the queue is emptied regardless.
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         pc_d    = redirect_target;
      end else begin
         if (push) begin
            ent_pc_d[tail_q]   = pc_q;
            ent_inst_d[tail_q] = push_inst;
            tail_d             = tail_q + PTR_W'(1);
            if (!trap_pend) begin
               pc_d = pc_q + 32'd4;
            end
         end
         if (pop) begin
            head_d = head_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

`ifdef IF_FETCH_MISALIGN_TRAP_EN
   always_comb begin
      state_d = state_q;
      for (int i = 0; i < int'(DEPTH); i++) begin
         ent_fault_d[i] = ent_fault_q[i];
      end
      if (redirect_valid) begin
         state_d = (redirect_pc[1:0] != 2'b00) ? ST_TRAP : ST_RUN;
      end else if (push) begin
         ent_fault_d[tail_q] = trap_pend;
         if (trap_pend) begin
            state_d = ST_HALT;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         for (int i = 0; i < int'(DEPTH); i++) begin
            ent_fault_q[i] <= 1'b0;
         end
      end else begin
         state_q <= state_d;
         for (int i = 0; i < int'(DEPTH); i++) begin
            ent_fault_q[i] <= ent_fault_d[i];
         end
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            ent_pc_q[i]   <= 32'h0;
            ent_inst_q[i] <= 32'h0;
         end
      end else begin
         pc_q    <= pc_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         for (int i = 0; i < int'(DEPTH); i++) begin
            ent_pc_q[i]   <= ent_pc_d[i];
            ent_inst_q[i] <= ent_inst_d[i];
         end
      end
   end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: queue-level reference model checked every
// cycle, plus literal expectations along the fetch/redirect/wrap/reset scenarios.
module tb_if_fetch_queue;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        fault;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic [31:0] out_pc_plus4;
   logic        out_fault;

   int vec_cnt = 0;
   int err_cnt = 0;

   // reference model state
   ent_t        exp_q[$];
   logic [31:0] m_pc    = RESET_PC;
   bit          m_halt  = 1'b0;
   bit          m_trap  = 1'b0;

   if_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc),
      .out_pc_plus4   (out_pc_plus4),
      .out_fault      (out_fault)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      case (addr)
         32'h0:   return 32'h11;
         32'h4:   return 32'h22;
         32'h8:   return 32'h33;
         32'hC:   return 32'h44;
         default: return addr ^ 32'h5A5A_0000;
      endcase
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic redirect(input logic [31:0] target, input logic ready);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      out_ready      = ready;
      step();
      redirect_valid = 1'b0;
   endtask

   // Reference model: queue of entries, updated at each active edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
         m_pc   = RESET_PC;
         m_halt = 1'b0;
         m_trap = 1'b0;
      end else begin
         bit pop;
         bit space;
         pop = (exp_q.size() != 0) && out_ready;
         if (redirect_valid) begin
            exp_q.delete();
            m_halt = 1'b0;
            m_trap = 1'b0;
`ifdef IF_FETCH_MISALIGN_TRAP_EN
            m_pc   = redirect_pc;
            m_trap = (redirect_pc % 4) != 0;
`else
            m_pc   = redirect_pc - (redirect_pc % 4);
`endif
         end else begin
            space = (exp_q.size() < DEPTH) || pop;
            if (pop) void'(exp_q.pop_front());
            if (!m_halt && space) begin
               if (m_trap) begin
                  exp_q.push_back('{pc: m_pc, inst: 32'h13, fault: 1'b1});
                  m_trap = 1'b0;
                  m_halt = 1'b1;
               end else begin
                  exp_q.push_back('{pc: m_pc, inst: mem_word(m_pc), fault: 1'b0});
                  m_pc = m_pc + 32'd4;
               end
            end
         end
      end
   end

   // Every-cycle comparison against the model, on the inactive edge.
   always @(negedge clk) begin
      check("imem_addr", imem_addr, m_pc);
      check("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
         check("out_pc", out_pc, exp_q[0].pc);
         check("out_inst", out_inst, exp_q[0].inst);
         check("out_pc_plus4", out_pc_plus4, exp_q[0].pc + 32'd4);
         check("out_fault", {31'b0, out_fault}, {31'b0, exp_q[0].fault});
      end
   end

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      check("rst_valid", {31'b0, out_valid}, 32'h0);
      check("rst_fault", {31'b0, out_fault}, 32'h0);
      check("rst_pc", out_pc, 32'h0);
      check("rst_inst", out_inst, 32'h0);
      check("rst_addr", imem_addr, 32'h0);

      // stream from RESET_PC
      @(negedge clk);
      #2 rst_n = 1'b1;
      step();
      check("s0_pc", out_pc, 32'h0);
      check("s0_inst", out_inst, 32'h11);
      check("s0_p4", out_pc_plus4, 32'h4);
      step();
      check("s1_pc", out_pc, 32'h4);
      check("s1_inst", out_inst, 32'h22);
      check("s1_p4", out_pc_plus4, 32'h8);
      step();
      check("s2_pc", out_pc, 32'h8);
      check("s2_inst", out_inst, 32'h33);
      check("s2_p4", out_pc_plus4, 32'hC);
      step();
      check("s3_pc", out_pc, 32'hC);
      check("s3_inst", out_inst, 32'h44);
      check("s3_p4", out_pc_plus4, 32'h10);

      // back-pressure: restart at 0 with decode stalled
      redirect(32'h0, 1'b0);
      check("bp_valid0", {31'b0, out_valid}, 32'h0);
      check("bp_addr0", imem_addr, 32'h0);
      for (int i = 0; i < 5; i++) step();
      check("bp_addr_frozen", imem_addr, 32'h8);
      check("bp_valid", {31'b0, out_valid}, 32'h1);
      check("bp_head", out_pc, 32'h0);
      out_ready = 1'b1;
      step();
      check("bp_head1", out_pc, 32'h4);
      step();
      check("bp_head2", out_pc, 32'h8);

      // redirect while full and popping
      redirect(32'h100, 1'b1);
      check("rd_valid", {31'b0, out_valid}, 32'h0);
      check("rd_addr", imem_addr, 32'h100);
      step();
      check("rd_pc", out_pc, 32'h100);
      check("rd_inst", out_inst, 32'h5A5A_0100);
      step();
      check("rd_pc1", out_pc, 32'h104);

      // 32-bit wrap
      redirect(32'hFFFF_FFF8, 1'b1);
      step();
      check("wr_pc0", out_pc, 32'hFFFF_FFF8);
      step();
      check("wr_pc1", out_pc, 32'hFFFF_FFFC);
      check("wr_p4", out_pc_plus4, 32'h0);
      step();
      check("wr_pc2", out_pc, 32'h0);
      check("wr_inst2", out_inst, 32'h11);

      // misaligned redirect
      redirect(32'h102, 1'b1);
`ifdef IF_FETCH_MISALIGN_TRAP_EN
      check("ma_addr", imem_addr, 32'h102);
      step();
      check("ma_valid", {31'b0, out_valid}, 32'h1);
      check("ma_pc", out_pc, 32'h102);
      check("ma_inst", out_inst, 32'h13);
      check("ma_fault", {31'b0, out_fault}, 32'h1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("ma_halted", {31'b0, out_valid}, 32'h0);
      end
      redirect(32'h200, 1'b1);
      step();
      check("ma_resume_pc", out_pc, 32'h200);
      check("ma_resume_fault", {31'b0, out_fault}, 32'h0);
`else
      check("ma_addr", imem_addr, 32'h100);
      step();
      check("ma_pc", out_pc, 32'h100);
      check("ma_fault", {31'b0, out_fault}, 32'h0);
`endif
      step();

      // asynchronous reset between edges
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("ar_valid", {31'b0, out_valid}, 32'h0);
      check("ar_addr", imem_addr, RESET_PC);
      @(negedge clk);
      #2 rst_n = 1'b1;
      step();
      check("ar_pc", out_pc, 32'h0);
      check("ar_inst", out_inst, 32'h11);
      step();
      check("ar_pc1", out_pc, 32'h4);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
